// File: rtl/uart_mmio_arbiter.sv
// ============================================================
// uart_mmio_arbiter: round-robin two-master arbiter for the UART MMIO port
// Rev 1.0
// ============================================================
`default_nettype none

module uart_mmio_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              wr_en_o,
   output logic              rd_en_o,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              busy_o,
   output logic              grant_id_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                wr_en_q, wr_en_d;
   logic                rd_en_q, rd_en_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic                busy_q, busy_d;
   logic                grant_q, grant_d;
   logic                last_q, last_d;

   logic                w_any_req;
   logic                w_win;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   // On a tie the master that did not win last time goes next.
   always_comb begin
      w_any_req   = m0_req_i | m1_req_i;
      w_win       = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
      w_sel_we    = w_win ? m1_we_i    : m0_we_i;
      w_sel_addr  = w_win ? m1_addr_i  : m0_addr_i;
      w_sel_wdata = w_win ? m1_wdata_i : m0_wdata_i;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      grant_d = grant_q;
      last_d  = last_q;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      busy_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_any_req) begin
               state_d = ST_ISSUE;
               grant_d = w_win;
               last_d  = w_win;
               we_d    = w_sel_we;
               addr_d  = w_sel_addr;
               wdata_d = w_sel_wdata;
               wr_en_d = w_sel_we;
               rd_en_d = ~w_sel_we;
               busy_d  = 1'b1;
            end
         end
         ST_ISSUE: begin
            state_d = ST_RESP;
            busy_d  = 1'b1;
            ack0_d  = ~grant_q;
            ack1_d  = grant_q;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         wr_en_q <= wr_en_d;
         rd_en_q <= rd_en_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Read data comes straight from the slave register during the ack cycle.
   assign m0_rdata_o = (ack0_q && !we_q) ? rdata_i : '0;
   assign m1_rdata_o = (ack1_q && !we_q) ? rdata_i : '0;

   assign m0_ack_o   = ack0_q;
   assign m1_ack_o   = ack1_q;
   assign addr_o     = addr_q;
   assign wdata_o    = wdata_q;
   assign wr_en_o    = wr_en_q;
   assign rd_en_o    = rd_en_q;
   assign busy_o     = busy_q;
   assign grant_id_o = grant_q;

endmodule

`default_nettype wire

// File: doc/uart_mmio_arbiter.md
# uart_mmio_arbiter

Two-master arbiter for the UART register block's MMIO port. It shares the single `addr/wdata/wr_en/rd_en/rdata` register interface between a host CPU port (m0) and a DMA/debug port (m1). Each transaction is sequenced as one single-cycle strobe on the register bus, and the response is routed back to the granted master. It sits directly in front of the UART register interface inside the UART top level.

## Interface
- `ADDR_W`, default 4: register address width; matches the UART register map.
- `DATA_W`, default 32: MMIO data width.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req`  in  1  m0 transaction request; level, held until `m0_ack`.
- `m0_we`  in  1  1 = write, 0 = read. Stable while `m0_req` is high.
- `m0_addr`  in  ADDR_W  register address.
- `m0_wdata`  in  DATA_W  write data.
- `m0_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`  out  DATA_W  read data; valid only while `m0_ack` is high for a read, 0 otherwise.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: identical set for m1.
- `addr`  out  ADDR_W  register bus address.
- `wdata`  out  DATA_W  register bus write data.
- `wr_en`  out  1  register bus write strobe.
- `rd_en`  out  1  register bus read strobe.
- `rdata`  in  DATA_W  register bus read data; registered by the slave, valid the cycle after `rd_en`.
- `busy`  out  1  high in ISSUE and RESP.
- `grant_id`  out  1  master owning the current or most recent transaction.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- **IDLE**
  - If any `req` is high, select a master, latch its `we/addr/wdata` and set `grant_id`, then go to ISSUE.
  - If no `req` is high, stay in IDLE.
- **ISSUE** (exactly one cycle)
  - `wr_en` = latched `we`; `rd_en` = !latched `we`. The other strobe is 0.
  - `addr`/`wdata` carry the latched command.
  - Go to RESP.
- **RESP** (exactly one cycle)
  - `m<grant_id>_ack` = 1.
  - For reads, `m<grant_id>_rdata` = bus `rdata` (combinational pass-through). For writes, it is 0.
  - Go to IDLE.
- **Arbitration:** round-robin with a `last` pointer.
  - Only one master requesting: that master wins.
  - Both requesting: the master != `last` wins.
  - `last` updates to the winner at grant.
- `req` is sampled only in IDLE. A `req` that is still high in ISSUE or RESP is not re-sampled until the next IDLE cycle.
- **Master rule:** drop `req` in the cycle after `ack`, unless a new command is presented. A `req` still high in IDLE is treated as a new transaction.
- A master that drops `req` before it is granted has no effect. No partial transactions occur: the latched command is issued regardless of later `req` changes.
- Exactly one bus strobe is issued per transaction. This guarantees a single RX_DATA pop per read, with no duplicate side effects.
- `addr`/`wdata` hold their last latched value outside ISSUE. `wr_en`/`rd_en` are 0 outside ISSUE.
- The non-granted master's `ack` is always 0 and its `rdata` is always 0.

## Timing
- **Reset** (takes effect at the rising edge where `rst` = 1):
  - State = IDLE, `last` = 1, so m0 wins the first tie.
  - All outputs are 0: `addr`, `wdata`, `wr_en`, `rd_en`, `m*_ack`, `m*_rdata`, `busy`, `grant_id`.
- **Reset mid-transaction:** reset in ISSUE or RESP aborts the transaction.
  - No `ack` is produced.
  - Strobes drop in the cycle after the reset edge.
  - The master must re-request.
- **Latency.** `req` is seen high in IDLE at edge T.
  - ISSUE occupies cycle T+1, with the strobe high.
  - The slave samples the strobe at the end of T+1.
  - RESP occupies cycle T+2, with `ack` and `rdata` valid.
  - The FSM is back in IDLE in cycle T+3.
- **Throughput:** one transaction per 3 cycles, back-to-back. Two masters requesting continuously alternate m0, m1, m0, …
- **Worst-case wait:** a requesting master is granted within 3 cycles of the other master's grant.
- **Outputs are registered:** `addr`, `wdata`, `wr_en`, `rd_en`, `ack`, `busy`, `grant_id`. Only `m*_rdata` is combinational from `rdata`.

## Test plan
- **Single m0 write:** m0 writes `addr=2`, `wdata=0x1B` at idle.
  - `wr_en`=1 with `addr=2`, `wdata=0x1B` exactly one cycle later.
  - `m0_ack` one cycle after that, with `m0_rdata=0`.
  - `rd_en` is never asserted.
- **Single m1 read:** m1 reads `addr=1`; the slave model returns `0x00010203`.
  - `rd_en` is asserted for exactly 1 cycle.
  - In the RESP cycle, `m1_ack`=1 and `m1_rdata=0x00010203`.
  - `m0_ack`=0 and `m0_rdata`=0 throughout.
- **Simultaneous requests:** both masters request continuously from reset for 4 transactions each.
  - Grant order is m0, m1, m0, m1, …
  - Each `ack` arrives 3 cycles apart.
  - Each master receives exactly 4 acks.
- **Back-to-back single master:** m0 issues 3 reads of `addr=4`, re-asserting `req` immediately after each `ack`.
  - Exactly 3 `rd_en` pulses, spaced 3 cycles apart.
  - Exactly 3 acks.
- **Reset mid-transaction:** assert `rst` during ISSUE of an m1 write.
  - No `m1_ack`.
  - All outputs are 0 the next cycle.
  - After release, a tie is won by m0.
- **Request withdrawn:** m1 pulses `req` for 1 cycle while an m0 transaction is in ISSUE.
  - m1 is never granted.
  - `busy` falls after the m0 RESP cycle.
